// File: rtl/multiciclo_secuenciador.sv
// Multi-cycle control FSM for the Procesador datapath: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Define SECUENCIADOR_PERF_EN to build the active-cycle counter on io_cycles.
module multiciclo_secuenciador #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_run,
    input  logic [31:0]      io_instr,
    input  logic             io_imem_valid,
    input  logic             io_dmem_ready,
    input  logic             io_branch_taken,
    output logic [2:0]       io_state,
    output logic             io_ir_we,
    output logic             io_pc_we,
    output logic             io_pc_sel,
    output logic             io_rf_we,
    output logic             io_alu_src_imm,
    output logic [3:0]       io_alu_op,
    output logic             io_dmem_req,
    output logic             io_dmem_we,
    output logic [1:0]       io_wb_sel,
    output logic             io_halt,
    output logic             io_fault,
    output logic [RET_W-1:0] io_retired,
    output logic [31:0]      io_cycles
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
        MEM = 3'd4, WB = 3'd5, HALT = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_t           state, next_state;
    logic [31:0]      ir;
    logic [7:0]       wait_cnt;
    logic             fault;
    logic [RET_W-1:0] retired;
    logic             retire, set_fault;

    wire unused_ir = &{1'b0, ir[31], ir[29:15]};

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_ecall, legal;
    assign is_r     = (ir[6:0] == OP_R);
    assign is_i     = (ir[6:0] == OP_I);
    assign is_ld    = (ir[6:0] == OP_LOAD);
    assign is_st    = (ir[6:0] == OP_STORE);
    assign is_br    = (ir[6:0] == OP_BRANCH);
    assign is_jal   = (ir[6:0] == OP_JAL);
    assign is_ecall = (ir[6:0] == OP_ECALL);
    assign legal    = is_r | is_i | is_ld | is_st | is_br | is_jal;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ir       <= '0;
            wait_cnt <= '0;
            fault    <= 1'b0;
            retired  <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH && io_imem_valid)
                ir <= io_instr;
            // Cleared whenever outside MEM, so every MEM visit starts at zero.
            wait_cnt <= (state == MEM && !io_dmem_ready) ? wait_cnt + 8'd1 : 8'd0;
            if (set_fault)
                fault <= 1'b1;
            if (retire)
                retired <= retired + RET_W'(1);
        end
    end

    always_comb begin
        next_state     = state;
        set_fault      = 1'b0;
        retire         = 1'b0;
        io_ir_we       = 1'b0;
        io_pc_we       = 1'b0;
        io_pc_sel      = 1'b0;
        io_rf_we       = 1'b0;
        io_dmem_req    = 1'b0;
        io_dmem_we     = 1'b0;
        io_wb_sel      = 2'd0;
        io_alu_op      = 4'd0;
        io_alu_src_imm = 1'b0;
        case (state)
            IDLE:   if (io_run) next_state = FETCH;
            FETCH: begin
                io_ir_we = io_imem_valid;
                if (io_imem_valid) next_state = DECODE;
            end
            DECODE: begin
                if (legal) next_state = EXEC;
                else begin
                    next_state = HALT;
                    set_fault  = !is_ecall;
                end
            end
            EXEC: begin
                if (is_ld || is_st) next_state = MEM;
                else if (is_br) begin
                    io_pc_we   = 1'b1;
                    io_pc_sel  = io_branch_taken;
                    retire     = 1'b1;
                    next_state = FETCH;
                end else next_state = WB;
            end
            MEM: begin
                io_dmem_req = 1'b1;
                io_dmem_we  = is_st;
                // Ready on the final allowed cycle still completes the access.
                if (io_dmem_ready) begin
                    if (is_st) begin
                        io_pc_we   = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else next_state = WB;
                end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
                    next_state = HALT;
                    set_fault  = 1'b1;
                end
            end
            WB: begin
                io_rf_we   = (ir[11:7] != 5'd0);
                io_wb_sel  = is_ld ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
                io_pc_we   = 1'b1;
                io_pc_sel  = is_jal;
                retire     = 1'b1;
                next_state = FETCH;
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase

        if (state == DECODE || state == EXEC || state == MEM || state == WB) begin
            io_alu_src_imm = is_i | is_ld | is_st;
            if (is_r)       io_alu_op = {ir[30], ir[14:12]};
            else if (is_i)  io_alu_op = {(ir[14:12] == 3'b101) & ir[30], ir[14:12]};
            else if (is_br) io_alu_op = 4'b1000;
        end

        // A reset cycle must never commit anything, whatever state it lands in.
        if (reset) begin
            io_ir_we    = 1'b0;
            io_pc_we    = 1'b0;
            io_rf_we    = 1'b0;
            io_dmem_req = 1'b0;
            io_dmem_we  = 1'b0;
            retire      = 1'b0;
            set_fault   = 1'b0;
        end
    end

    assign io_state   = state;
    assign io_halt    = (state == HALT);
    assign io_fault   = fault;
    assign io_retired = retired;

`ifdef SECUENCIADOR_PERF_EN
    logic [31:0] cycles;
    always_ff @(posedge clock) begin
        if (reset)
            cycles <= '0;
        else if (state != IDLE && state != HALT)
            cycles <= cycles + 32'd1;
    end
    assign io_cycles = cycles;
`else
    assign io_cycles = 32'd0;
`endif
endmodule
